iob_cache_be_arbiter: RTL

// - Round-robin arbiter sharing one back-end memory port between N cache back-ends (e.g. I-cache and D-cache).
// - Sits between the be_* ports of N cache back-ends and the single external memory.
// - Routes each request and its read response.
// - One transaction in flight at a time; the grant is held until that transaction completes.

---
 rtl/iob_cache_be_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter that shares one back-end memory port between
// N_MASTERS cache back-ends. One transaction is in flight at a time and
// the grant is held until the write is accepted or the read data returns.
module iob_cache_be_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
) (
  input  logic                            clk_i,
  input  logic                            arst_n_i,
  input  logic                            cke_i,
  input  logic [N_MASTERS-1:0]            m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
  output logic                            be_valid_o,
  output logic [ADDR_W-1:0]               be_addr_o,
  output logic [DATA_W-1:0]               be_wdata_o,
  output logic [DATA_W/8-1:0]             be_wstrb_o,
  input  logic                            be_ready_i,
  input  logic                            be_rvalid_i,
  input  logic [DATA_W-1:0]               be_rdata_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   last_reg, last_next;

  logic               sel_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;

  logic               rr_hi_found, rr_lo_found;
  logic [IDX_W-1:0]   rr_hi_idx, rr_lo_idx, rr_idx;
  logic               rd_pulse;

  // Multiplex the granted master's request fields
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_reg == IDX_W'(k)) begin
        sel_valid = m_valid_i[k];
        sel_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata_i[k*DATA_W +: DATA_W];
        sel_wstrb = m_wstrb_i[k*STRB_W +: STRB_W];
      end
    end
  end

  // Round-robin search: lowest requester above last wins, else wrap to the
  // lowest requester at or below last (works for non-power-of-2 counts)
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_found = 1'b0;
    rr_lo_idx   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (m_valid_i[k]) begin
        if (IDX_W'(k) > last_reg) begin
          if (!rr_hi_found) begin
            rr_hi_found = 1'b1;
            rr_hi_idx   = IDX_W'(k);
          end
        end else if (!rr_lo_found) begin
          rr_lo_found = 1'b1;
          rr_lo_idx   = IDX_W'(k);
        end
      end
    end
    rr_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
  end

  // Next-state logic and the shared request valid
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    be_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|m_valid_i) begin
          grant_next = rr_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        be_valid_o = sel_valid;
        if (!sel_valid) begin
          // requester withdrew before acceptance: no completion recorded
          state_next = IDLE;
        end else if (be_ready_i) begin
          if (|sel_wstrb) begin
            last_next  = grant_reg;
            state_next = IDLE;
          end else begin
            state_next = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (be_rvalid_i) begin
          last_next  = grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are zeroed whenever no request is presented
  always_comb begin
    be_addr_o  = be_valid_o ? sel_addr  : '0;
    be_wdata_o = be_valid_o ? sel_wdata : '0;
    be_wstrb_o = be_valid_o ? sel_wstrb : '0;
    rd_pulse   = (state_reg == WAIT_RD) && be_rvalid_i;
  end

  // Per-master handshake routing; read data is broadcast to every slot
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_slot
      assign m_ready_o[gi]  = (grant_reg == IDX_W'(gi)) && be_valid_o && be_ready_i;
      assign m_rvalid_o[gi] = (grant_reg == IDX_W'(gi)) && rd_pulse;
      assign m_rdata_o[gi*DATA_W +: DATA_W] = be_rdata_i;
    end
  endgenerate

  // State, grant and round-robin pointer; all hold while cke_i is low
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= IDX_W'(N_MASTERS - 1);
    end else if (cke_i) begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

endmodule
